// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: icache read port, hazard/redirect/halt
// controls in, and the IF/ID-facing instruction outputs.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_npc;
    logic        flush_out;

    modport master (
        input  ihit, iload, stall,
        input  redirect, redirect_pc, halt,
        output iREN, iaddr,
        output fetch_valid, fetch_instr,
        output fetch_pc, fetch_npc, flush_out
    );

    modport slave (
        output ihit, iload, stall,
        output redirect, redirect_pc, halt,
        input  iREN, iaddr,
        input  fetch_valid, fetch_instr,
        input  fetch_pc, fetch_npc, flush_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the icache, feeds IF/ID.
// IF_PERF_CNT_EN adds fetch_count / miss_cycles counters.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_unit_if.master  fif
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   miss_cycles
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buf_instr, buf_n;
    logic [31:0] redir_pc, redir_n;

    logic        ren;
    logic        valid;
    logic        flush;
    logic [31:0] instr;

    // State, PC, hold buffer and pending redirect target
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            buf_instr <= '0;
            redir_pc  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            buf_instr <= buf_n;
            redir_pc  <= redir_n;
        end
    end

    // Next-state and output decode; redirect outranks halt and stall
    always_comb begin
        state_n = state;
        pc_n    = pc;
        buf_n   = buf_instr;
        redir_n = redir_pc;
        ren     = 1'b0;
        valid   = 1'b0;
        flush   = 1'b0;
        instr   = fif.iload;
        unique case (state)
            FETCH: begin
                ren   = 1'b1;
                flush = fif.redirect;
                valid = fif.ihit & ~fif.redirect;
                if (fif.redirect) begin
                    if (fif.ihit) begin
                        pc_n = fif.redirect_pc;
                    end else begin
                        // miss in flight: let it land before re-addressing
                        redir_n = fif.redirect_pc;
                        state_n = DRAIN;
                    end
                end else if (fif.halt) begin
                    state_n = HALTED;
                end else if (fif.ihit) begin
                    if (fif.stall) begin
                        buf_n   = fif.iload;
                        state_n = HOLD;
                    end else begin
                        pc_n = pc + 32'd4;
                    end
                end
            end
            HOLD: begin
                instr = buf_instr;
                flush = fif.redirect;
                valid = ~fif.redirect;
                if (fif.redirect) begin
                    pc_n    = fif.redirect_pc;
                    state_n = FETCH;
                end else if (fif.halt) begin
                    state_n = HALTED;
                end else if (!fif.stall) begin
                    pc_n    = pc + 32'd4;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                ren   = 1'b1;
                flush = fif.redirect;
                if (fif.redirect) begin
                    redir_n = fif.redirect_pc;
                end
                if (fif.ihit) begin
                    pc_n    = fif.redirect ? fif.redirect_pc
                                           : redir_pc;
                    state_n = FETCH;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign fif.iREN        = ren;
    assign fif.iaddr       = pc;
    assign fif.fetch_valid = valid;
    assign fif.fetch_instr = instr;
    assign fif.fetch_pc    = pc;
    assign fif.fetch_npc   = pc + 32'd4;
    assign fif.flush_out   = flush;

`ifdef IF_PERF_CNT_EN
    // Accepted-instruction and miss-cycle counters, free-running wrap
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            miss_cycles <= '0;
        end else begin
            if (valid & ~fif.stall)
                fetch_count <= fetch_count + 32'd1;
            if (ren & ~fif.ihit)
                miss_cycles <= miss_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined core; sits directly upstream of the IF/ID latch.
- Owns the PC and drives the instruction-cache read port (iREN/iaddr, completed by ihit).
- Presents instr/pc/npc to IF/ID with a valid qualifier and raises a flush on control-flow redirect.
- Holds a fetched instruction across IF/ID stalls, drops wrong-path fetches on redirect, and stops fetching on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  icache: iload is valid for iaddr this cycle.
- iload  input  32  icache instruction data.
- iREN  output  1  icache read enable.
- iaddr  output  32  icache read address; always equals pc.
- stall  input  1  hazard unit: IF/ID must not capture this cycle.
- redirect  input  1  branch/jump resolved to a target other than the fetched path.
- redirect_pc  input  32  target address for redirect.
- halt  input  1  decode saw a halt instruction.
- fetch_valid  output  1  fetch_instr/pc/npc are valid for IF/ID.
- fetch_instr  output  32  instruction to IF/ID.
- fetch_pc  output  32  address of fetch_instr.
- fetch_npc  output  32  fetch_pc + 4.
- flush_out  output  1  one-cycle pulse that flushes IF/ID (wrong-path instruction).

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset: pc=PC_INIT, state=FETCH, hold buffer=0, redirect latch=0.
- Reset outputs: fetch_valid=0, flush_out=0, iREN=1, iaddr=PC_INIT.
- Deasserting nRST mid-miss abandons the miss; the first cycle out of reset re-requests PC_INIT.
- Arithmetic: npc = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0. Redirect targets are not checked for alignment.
- States:
  - FETCH: iREN=1.
    - On ihit: fetch_valid=1; fetch_instr=iload combinationally; fetch_pc=pc; fetch_npc=pc+4.
    - ihit & !stall: pc<=pc+4, stay in FETCH.
    - ihit & stall: buffer iload/pc, go to HOLD.
    - !ihit: fetch_valid=0, pc held.
  - HOLD: iREN=0; fetch_valid=1 from the buffer.
    - When stall drops: pc<=buffered pc+4, go to FETCH.
    - Outputs are stable while stall is high.
  - DRAIN: entered when redirect arrives in FETCH with !ihit (miss outstanding).
    - iREN=1 and iaddr=old pc until ihit; the cache is never re-addressed mid-miss.
    - On ihit: data dropped, fetch_valid=0, pc<=latched redirect_pc, go to FETCH.
  - HALTED: iREN=0, fetch_valid=0, pc frozen. Only nRST exits.
- Redirect (highest priority):
  - flush_out=1 in the same cycle as redirect.
  - fetch_valid is forced 0 that cycle, even if ihit.
  - In FETCH with ihit, or in HOLD: pc<=redirect_pc, state<=FETCH, buffer discarded.
  - In FETCH with !ihit: latch redirect_pc, go to DRAIN.
  - In DRAIN: a newer redirect_pc overwrites the latch.
- Priority when several events coincide:
  - redirect over stall.
  - redirect over halt: the halt is wrong-path and is ignored.
- Halt with no redirect:
  - From FETCH/HOLD: go to HALTED next cycle; any current or buffered instruction is still presented that cycle.
  - From DRAIN: the halt is ignored.
- Redirect while HALTED is ignored.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_count[31:0] and miss_cycles[31:0], both reset to 0.
  - fetch_count increments on each instruction accepted by IF/ID (fetch_valid & !stall & !redirect).
  - miss_cycles increments each cycle iREN & !ihit.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with PC_INIT=0, ihit=1 every cycle, iload=pc-tagged words, no stall -> iaddr 0,4,8,C on successive cycles; fetch_valid=1; fetch_npc=fetch_pc+4.
- ihit at pc=8, stall held 3 cycles -> HOLD, iREN=0, fetch_instr/fetch_pc=8 stable for 3 cycles; after stall drops, the next request is iaddr=C.
- Miss at pc=10 (ihit low 4 cycles), redirect to 40 in the 2nd miss cycle -> flush_out pulse; iaddr stays 10 until ihit; that data dropped with fetch_valid=0; next iaddr=40.
- redirect to 80, halt and stall all in one cycle with ihit -> flush_out=1, fetch_valid=0, next iaddr=80, not halted.
- halt at pc=20 -> HALTED next cycle; iREN=0 indefinitely; a redirect to 0 is ignored; an nRST pulse restarts at PC_INIT.
- With IF_PERF_CNT_EN: 10 hits, then one 5-cycle miss, then 1 accepted instruction -> fetch_count=11, miss_cycles=5; nRST clears both counters to 0.
